// File: rtl/cpu_trace_monitor.sv
// Trace and run-control unit: samples PC plus NCH probe words per enabled cycle into a record FIFO and streams records out word by word.
// Optional build macro TRACE_CHANGE_ONLY_EN: push a record only when the probe values differ from the last pushed record.
module cpu_trace_monitor #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int NCH        = 8,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 27500,
  parameter int CNT_W      = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                en_i,
  input  logic [AW-1:0]       pc_i,
  input  logic [NCH*DW-1:0]   probe_i,
  input  logic                trace_ready_i,
  output logic                trace_valid_o,
  output logic [DW-1:0]       trace_data_o,
  output logic                trace_last_o,
  output logic [CNT_W-1:0]    cycle_cnt_o,
  output logic                overflow_o,
  output logic                done_o
);

  localparam int RW = (NCH + 1) * DW;
  localparam int PW = $clog2(DEPTH);
  localparam int IW = $clog2(NCH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_CYCLES);
  localparam logic [IW-1:0]    IDX_LAST = IW'(NCH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PW:0]      wr_ptr_q, wr_ptr_d;
  logic [PW:0]      rd_ptr_q, rd_ptr_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic [IW-1:0]    idx_q, idx_d;

  logic [RW-1:0]    mem [DEPTH];
  logic [RW-1:0]    rec_q;
  logic [RW-1:0]    rec_in;
  logic [DW-1:0]    word_w [NCH+1];

  logic empty, full, sample, push_req, push, pop;
  logic word_fire, last_word, ser_free;

  assign rec_in[DW-1:0]  = DW'(pc_i);
  assign rec_in[RW-1:DW] = probe_i;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                 (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);

  assign word_fire = valid_q && trace_ready_i;
  assign last_word = (idx_q == IDX_LAST);
  // Serializer can take a new record now if idle, or if its last word leaves this edge.
  assign ser_free  = !valid_q || (word_fire && last_word);
  assign pop       = ser_free && !empty;

  assign sample = en_i && (cnt_q != CNT_MAX) &&
                  ((state_q == S_IDLE) || (state_q == S_RUN));

`ifdef TRACE_CHANGE_ONLY_EN
  logic [NCH*DW-1:0] last_probe_q;
  logic              have_last_q;

  assign push_req = sample && (!have_last_q || (probe_i != last_probe_q));

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      last_probe_q <= '0;
      have_last_q  <= 1'b0;
    end else if (push) begin
      last_probe_q <= probe_i;
      have_last_q  <= 1'b1;
    end
  end
`else
  assign push_req = sample;
`endif

  // A full FIFO still accepts when a record leaves on the same edge.
  assign push = push_req && (!full || pop);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    idx_d    = idx_q;

    if (sample) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (sample) begin
          state_d = (cnt_d == CNT_MAX) ? S_DRAIN : S_RUN;
        end
      end
      S_RUN: begin
        if (sample && (cnt_d == CNT_MAX)) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (empty && !valid_q) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (push) begin
      wr_ptr_d = wr_ptr_q + (PW+1)'(1);
    end
    if (push_req && !push) begin
      ovf_d = 1'b1;
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + (PW+1)'(1);
      valid_d  = 1'b1;
      idx_d    = '0;
    end else if (word_fire) begin
      if (last_word) begin
        valid_d = 1'b0;
        idx_d   = '0;
      end else begin
        idx_d = idx_q + IW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
    end
  end

  // Storage has no reset so it maps onto block RAM; on a full push+pop the read sees the old record.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q[PW-1:0]] <= rec_in;
    end
    if (pop) begin
      rec_q <= mem[rd_ptr_q[PW-1:0]];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= NCH; gi++) begin : g_word
      assign word_w[gi] = rec_q[gi*DW +: DW];
    end
  endgenerate

  assign trace_valid_o = valid_q;
  assign trace_data_o  = valid_q ? word_w[idx_q] : '0;
  assign trace_last_o  = valid_q && last_word;
  assign cycle_cnt_o   = cnt_q;
  assign overflow_o    = ovf_q;
  assign done_o        = (state_q == S_DONE);

endmodule
